// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch state encoding, reset defaults and opcodes
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;

   function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; squash beats stall beats load
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        squash,
   input  logic        stall,
   input  logic        load,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] pc_plus4_in,
   output logic        valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;

   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      // squashed slots keep their old PC fields so the valid flag alone marks them dead
      if (squash) begin
         valid_d = 1'b0;
         instr_d = NOP_WORD;
      end else if (!stall) begin
         if (load) begin
            valid_d    = 1'b1;
            instr_d    = instr_in;
            pc_d       = pc_in;
            pc_plus4_d = pc_plus4_in;
         end else begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= NOP_WORD;
         pc_q       <= 32'h0;
         pc_plus4_q <= 32'h0;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc       = pc_q;
   assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch stage: PC, boot/run/halt FSM, fault trap, IF/ID
// Performance counters are built only when FETCH_PERF_CNT_EN is defined.
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter int          IMEM_BYTES = 512,
   parameter logic [31:0] NOP_WORD   = DEF_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic        imem_en,
   input  logic [31:0] imem_data,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_plus4,
   output logic        fetch_fault,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
);

   localparam logic [31:0] MAX_PC = 32'(IMEM_BYTES - 4);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         fault_q, fault_d;
   logic [31:0]  pc_plus4;
   logic         pc_bad;
   logic         redirect_legal;
   logic         ifid_squash;

   always_comb begin
      pc_plus4       = next_word_pc(pc_q);
      pc_bad         = (state_q == FETCH_RUN) && ((pc_q[1:0] != 2'b00) || (pc_q > MAX_PC));
      redirect_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= MAX_PC);
      imem_en        = (state_q == FETCH_RUN) && !pc_bad && !stall;
      ifid_squash    = flush || redirect_valid;

      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      case (state_q)
         FETCH_BOOT: begin
            state_d = FETCH_RUN;
            if (redirect_valid) pc_d = redirect_pc;
         end
         FETCH_RUN: begin
            // a redirect in the same cycle replaces the bad PC before it can trap
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (pc_bad) begin
               fault_d = 1'b1;
               state_d = FETCH_HALT;
            end else if (!stall) begin
               pc_d = pc_plus4;
            end
         end
         FETCH_HALT: begin
            if (redirect_valid && redirect_legal) begin
               pc_d    = redirect_pc;
               fault_d = 1'b0;
               state_d = FETCH_RUN;
            end
         end
         default: state_d = FETCH_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_BOOT;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   assign imem_addr   = pc_q;
   assign fetch_fault = fault_q;

   if_id_reg #(
      .NOP_WORD(NOP_WORD)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .squash     (ifid_squash),
      .stall      (stall),
      .load       (imem_en),
      .instr_in   (imem_data),
      .pc_in      (pc_q),
      .pc_plus4_in(pc_plus4),
      .valid      (ifid_valid),
      .instr      (ifid_instr),
      .pc         (ifid_pc),
      .pc_plus4   (ifid_pc_plus4)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        load_real;
   logic        load_bubble;

   always_comb begin
      load_real    = !ifid_squash && imem_en;
      // a stall-hold edge leaves IF/ID untouched, so it is neither a fetch nor a bubble
      load_bubble  = !load_real && (ifid_squash || !stall);
      fetch_cnt_d  = fetch_cnt_q + {31'h0, load_real};
      bubble_cnt_d = bubble_cnt_q + {31'h0, load_bubble};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign fetch_count  = fetch_cnt_q;
   assign bubble_count = bubble_cnt_q;
`else
   assign fetch_count  = 32'h0;
   assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_data;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic        fetch_fault;
   logic [31:0] fetch_count;
   logic [31:0] bubble_count;

   logic [31:0] imem [0:127];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   assign imem_data = imem[imem_addr[8:2]];

   if_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_addr     (imem_addr),
      .imem_en       (imem_en),
      .imem_data     (imem_data),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_pc_plus4 (ifid_pc_plus4),
      .fetch_fault   (fetch_fault),
      .fetch_count   (fetch_count),
      .bubble_count  (bubble_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
      chk({tag, "_instr"}, ifid_instr, 32'h0);
      chk({tag, "_ifid_pc"}, ifid_pc, 32'h0);
      chk({tag, "_pc4"}, ifid_pc_plus4, 32'h0);
      chk({tag, "_fault"}, {31'h0, fetch_fault}, 32'h0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_en"}, {31'h0, imem_en}, 32'h0);
      chk({tag, "_fcnt"}, fetch_count, 32'h0);
      chk({tag, "_bcnt"}, bubble_count, 32'h0);
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(negedge clk);
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 128; i++) imem[i] = 32'h1000_0000 + i;
      imem[0] = 32'h8c23_0004;
      imem[1] = 32'h00c6_6020;

      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");

      rst_n = 1'b1;
      #1 chk("boot_en", {31'h0, imem_en}, 32'h0);
      @(negedge clk);
      chk("run_addr", imem_addr, 32'h0);
      chk("run_en", {31'h0, imem_en}, 32'h1);
      chk("run_bubble", {31'h0, ifid_valid}, 32'h0);
      @(negedge clk);
      chk("w0_instr", ifid_instr, 32'h8c23_0004);
      chk("w0_pc", ifid_pc, 32'h0);
      chk("w0_pc4", ifid_pc_plus4, 32'h4);
      chk("w0_valid", {31'h0, ifid_valid}, 32'h1);
      chk("w0_addr", imem_addr, 32'h4);
      @(negedge clk);
      chk("w1_instr", ifid_instr, 32'h00c6_6020);
      chk("w1_pc", ifid_pc, 32'h4);
      chk("w1_addr", imem_addr, 32'h8);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_addr", imem_addr, 32'h8);
         chk("stall_instr", ifid_instr, 32'h00c6_6020);
         chk("stall_pc", ifid_pc, 32'h4);
         chk("stall_valid", {31'h0, ifid_valid}, 32'h1);
         chk("stall_en", {31'h0, imem_en}, 32'h0);
      end
      stall = 1'b0;
      @(negedge clk);
      chk("unstall_addr", imem_addr, 32'hc);
      chk("unstall_instr", ifid_instr, 32'h1000_0002);
      chk("unstall_pc", ifid_pc, 32'h8);

      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_valid", {31'h0, ifid_valid}, 32'h0);
      chk("flush_instr", ifid_instr, 32'h0);
      chk("flush_pc_hold", ifid_pc, 32'h8);
      chk("flush_addr", imem_addr, 32'h10);

      stall = 1'b1;
      redirect_to(32'h20);
      stall = 1'b0;
      chk("redir_addr", imem_addr, 32'h20);
      chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
      chk("redir_instr", ifid_instr, 32'h0);
      @(negedge clk);
      chk("tgt_instr", ifid_instr, 32'h1000_0008);
      chk("tgt_pc", ifid_pc, 32'h20);
      chk("tgt_addr", imem_addr, 32'h24);

      redirect_to(32'h6);
      chk("mis_addr", imem_addr, 32'h6);
      chk("mis_en", {31'h0, imem_en}, 32'h0);
      chk("mis_nofault", {31'h0, fetch_fault}, 32'h0);
      @(negedge clk);
      chk("halt_fault", {31'h0, fetch_fault}, 32'h1);
      chk("halt_en", {31'h0, imem_en}, 32'h0);
      chk("halt_valid", {31'h0, ifid_valid}, 32'h0);
      chk("halt_addr", imem_addr, 32'h6);

      redirect_to(32'h201);
      chk("bad_redir_fault", {31'h0, fetch_fault}, 32'h1);
      chk("bad_redir_addr", imem_addr, 32'h6);
      chk("bad_redir_en", {31'h0, imem_en}, 32'h0);

      redirect_to(32'h0);
      chk("clear_fault", {31'h0, fetch_fault}, 32'h0);
      chk("clear_addr", imem_addr, 32'h0);
      chk("clear_en", {31'h0, imem_en}, 32'h1);
      chk("clear_valid", {31'h0, ifid_valid}, 32'h0);
      @(negedge clk);
      chk("resume_instr", ifid_instr, 32'h8c23_0004);
      chk("resume_addr", imem_addr, 32'h4);

      redirect_to(32'h1f4);
      chk("top_addr", imem_addr, 32'h1f4);
      repeat (2) @(negedge clk);
      chk("last_addr", imem_addr, 32'h1fc);
      chk("last_en", {31'h0, imem_en}, 32'h1);
      @(negedge clk);
      chk("last_instr", ifid_instr, 32'h1000_007f);
      chk("last_pc", ifid_pc, 32'h1fc);
      chk("last_pc4", ifid_pc_plus4, 32'h200);
      chk("oor_addr", imem_addr, 32'h200);
      chk("oor_en", {31'h0, imem_en}, 32'h0);
      chk("oor_nofault", {31'h0, fetch_fault}, 32'h0);
      @(negedge clk);
      chk("oor_fault", {31'h0, fetch_fault}, 32'h1);
      chk("oor_valid", {31'h0, ifid_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, 32'd8);
      chk("bubble_count", bubble_count, 32'd9);
`else
      chk("fetch_count_off", fetch_count, 32'h0);
      chk("bubble_count_off", bubble_count, 32'h0);
`endif

      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("halt_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
